dp_row_sched: RTL and testbench

- Sequencing controller for one row of M sparse dot-product lanes.
- Accepts a job of `job_tiles` weight tiles × `job_steps` activation steps per tile.
- Per tile: fetches weights, issues one load pulse, then issues one execute pulse per accepted activation.
- Steers lane psum_in between zero (first step of a job) and feedback (all later steps); signals done after the lane pipeline drains.
- Sits between the job/weight/activation buffers and the lane row's shared load/execute/a_select controls.

---
 rtl/dp_pkg.sv | 24 ++
 rtl/dp_row_sched.sv | 143 ++++++++++++++
 tb/tb_dp_row_sched.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product row: scheduler state encoding and
// default geometry constants also used by the lane row.
package dp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  localparam int M_DEF        = 4;
  localparam int TW_DEF       = 8;
  localparam int SW_DEF       = 8;
  localparam int PIPE_LAT_DEF = 1;

  // Lane-row geometry defaults, kept here so row and scheduler agree.
  localparam int BW_DEF       = 8;
  localparam int PSUM_BW_DEF  = 32;
  localparam int NNZ_DEF      = 2;
  localparam int N_DEF        = 4;

endpackage

// File: rtl/dp_row_sched.sv
// Sequencer for one row of sparse dot-product lanes: per tile fetch weights,
// pulse load, then pulse execute once per accepted activation; done after drain.
module dp_row_sched
  import dp_pkg::*;
#(
  parameter int M        = M_DEF,
  parameter int TW       = TW_DEF,
  parameter int SW       = SW_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [TW-1:0] job_tiles,
  input  logic [SW-1:0] job_steps,
  output logic          wt_req,
  input  logic          wt_valid,
  input  logic          act_valid,
  output logic          act_ready,
  output logic          row_load,
  output logic          row_execute,
  output logic [M-1:0]  row_a_select,
  output logic          psum_fb,
  output logic [TW-1:0] tile_idx,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; valid from the source never depends on ready. Strobes are Mealy so
  // the lanes capture weight/activation data in that same transfer cycle.

  localparam int DW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT - 1) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE_LAT > 1) ? PIPE_LAT - 2 : 0);

  sched_state_e  state_q, state_d;
  logic [TW-1:0] tiles_q, tiles_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [SW-1:0] step_q, step_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          fb_q, fb_d;

  logic last_step, last_tile;

  assign last_step = (step_q == steps_q - SW'(1));
  assign last_tile = (tile_q == tiles_q - TW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tiles_q <= '0;
      steps_q <= '0;
      tile_q  <= '0;
      step_q  <= '0;
      drain_q <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      steps_q <= steps_d;
      tile_q  <= tile_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      fb_q    <= fb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tiles_d      = tiles_q;
    steps_d      = steps_q;
    tile_d       = tile_q;
    step_d       = step_q;
    drain_d      = drain_q;
    fb_d         = fb_q;
    job_ready    = 1'b0;
    wt_req       = 1'b0;
    act_ready    = 1'b0;
    row_load     = 1'b0;
    row_execute  = 1'b0;
    row_a_select = '0;
    psum_fb      = 1'b0;
    done         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          tiles_d = job_tiles;
          steps_d = job_steps;
          tile_d  = '0;
          step_d  = '0;
          fb_d    = 1'b0;
          state_d = (job_tiles == '0 || job_steps == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        wt_req   = 1'b1;
        row_load = wt_valid;
        if (wt_valid) begin
          step_d  = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        act_ready    = 1'b1;
        row_execute  = act_valid;
        row_a_select = {M{step_q[0]}};
        psum_fb      = fb_q;
        if (act_valid) begin
          fb_d = 1'b1;
          if (!last_step) begin
            step_d = step_q + SW'(1);
          end else if (!last_tile) begin
            tile_d  = tile_q + TW'(1);
            state_d = ST_LOAD;
          end else begin
            drain_d = '0;
            // A one-cycle lane pipeline has its result ready next cycle.
            state_d = (PIPE_LAT <= 1) ? ST_DONE : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = ST_DONE;
        else                       drain_d = drain_q + DW'(1);
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tile_idx  = tile_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dp_row_sched.sv
// Bench for dp_row_sched: two instances (lane latency 1 and 3) share stimulus
// and are checked every cycle against a job-level model of the schedule.
module tb_dp_row_sched;

  localparam int M  = 4;
  localparam int TW = 8;
  localparam int SW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          job_valid = 1'b0;
  logic [TW-1:0] job_tiles = '0;
  logic [SW-1:0] job_steps = '0;
  logic          wt_valid  = 1'b0;
  logic          act_valid = 1'b0;

  logic          job_ready_w   [2];
  logic          wt_req_w      [2];
  logic          act_ready_w   [2];
  logic          row_load_w    [2];
  logic          row_execute_w [2];
  logic [M-1:0]  row_a_select_w[2];
  logic          psum_fb_w     [2];
  logic [TW-1:0] tile_idx_w    [2];
  logic          busy_w        [2];
  logic          done_w        [2];
  logic [2:0]    dbg_state_w   [2];

  dp_row_sched #(.M(M), .TW(TW), .SW(SW), .PIPE_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready_w[0]),
    .job_tiles(job_tiles), .job_steps(job_steps),
    .wt_req(wt_req_w[0]), .wt_valid(wt_valid),
    .act_valid(act_valid), .act_ready(act_ready_w[0]),
    .row_load(row_load_w[0]), .row_execute(row_execute_w[0]),
    .row_a_select(row_a_select_w[0]), .psum_fb(psum_fb_w[0]),
    .tile_idx(tile_idx_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .dbg_state(dbg_state_w[0])
  );

  dp_row_sched #(.M(M), .TW(TW), .SW(SW), .PIPE_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready_w[1]),
    .job_tiles(job_tiles), .job_steps(job_steps),
    .wt_req(wt_req_w[1]), .wt_valid(wt_valid),
    .act_valid(act_valid), .act_ready(act_ready_w[1]),
    .row_load(row_load_w[1]), .row_execute(row_execute_w[1]),
    .row_a_select(row_a_select_w[1]), .psum_fb(psum_fb_w[1]),
    .tile_idx(tile_idx_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .dbg_state(dbg_state_w[1])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  // Job-level model: phase 0 idle, 1 awaiting weights, 2 computing,
  // 3 waiting for lane results, 4 result ready. Progress is tracked as the
  // total number of executes issued in the job.
  int lat[2] = '{1, 3};
  int ph[2], m_tiles[2], m_steps[2], execs[2], last_tile[2], drain_left[2];

  // Per-test statistics observed on the DUT, pinned by literal expectations.
  int n_exec[2], n_load[2], n_wtreq[2], n_done[2], n_fb[2];
  int acc_cyc[2], done_gap[2], prev_done[2], done_int[2];

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      n_exec[i] = 0; n_load[i] = 0; n_wtreq[i] = 0; n_done[i] = 0; n_fb[i] = 0;
      acc_cyc[i] = 0; done_gap[i] = -1; prev_done[i] = -1; done_int[i] = -1;
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; m_tiles[i] = 0; m_steps[i] = 0; execs[i] = 0;
      last_tile[i] = 0; drain_left[i] = 0;
    end
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        logic [M-1:0] e_sel;
        int e_tile;
        if (!reset) begin
          ph[i] = 0; execs[i] = 0; last_tile[i] = 0; drain_left[i] = 0;
        end
        e_tile = (ph[i] == 1 || ph[i] == 2) ? execs[i] / m_steps[i] : last_tile[i];
        e_sel  = (ph[i] == 2 && (execs[i] % m_steps[i]) % 2 == 1) ? {M{1'b1}} : '0;
        check("job_ready",   i, 32'(job_ready_w[i]),   32'(ph[i] == 0));
        check("busy",        i, 32'(busy_w[i]),        32'(ph[i] != 0));
        check("wt_req",      i, 32'(wt_req_w[i]),      32'(ph[i] == 1));
        check("row_load",    i, 32'(row_load_w[i]),    32'(ph[i] == 1 && wt_valid));
        check("act_ready",   i, 32'(act_ready_w[i]),   32'(ph[i] == 2));
        check("row_execute", i, 32'(row_execute_w[i]), 32'(ph[i] == 2 && act_valid));
        check("a_select",    i, 32'(row_a_select_w[i]), 32'(e_sel));
        check("psum_fb",     i, 32'(psum_fb_w[i]),     32'(ph[i] == 2 && execs[i] > 0));
        check("tile_idx",    i, 32'(tile_idx_w[i]),    32'(e_tile));
        check("done",        i, 32'(done_w[i]),        32'(ph[i] == 4));

        if (row_execute_w[i]) n_exec[i]++;
        if (row_execute_w[i] && psum_fb_w[i]) n_fb[i]++;
        if (row_load_w[i]) n_load[i]++;
        if (wt_req_w[i]) n_wtreq[i]++;
        if (reset && job_valid && job_ready_w[i]) acc_cyc[i] = cyc;
        if (done_w[i]) begin
          n_done[i]++;
          done_gap[i] = cyc - acc_cyc[i];
          if (prev_done[i] >= 0) done_int[i] = cyc - prev_done[i];
          prev_done[i] = cyc;
        end

        // Advance the model with the inputs that the coming rising edge sees.
        if (reset) begin
          case (ph[i])
            0: if (job_valid) begin
              m_tiles[i] = int'(job_tiles);
              m_steps[i] = int'(job_steps);
              execs[i] = 0;
              last_tile[i] = 0;
              ph[i] = (job_tiles == 0 || job_steps == 0) ? 4 : 1;
            end
            1: if (wt_valid) ph[i] = 2;
            2: if (act_valid) begin
              execs[i]++;
              if (execs[i] % m_steps[i] == 0) begin
                if (execs[i] == m_tiles[i] * m_steps[i]) begin
                  last_tile[i] = m_tiles[i] - 1;
                  if (lat[i] == 1) ph[i] = 4;
                  else begin
                    drain_left[i] = lat[i] - 1;
                    ph[i] = 3;
                  end
                end else begin
                  ph[i] = 1;
                end
              end
            end
            3: begin
              drain_left[i]--;
              if (drain_left[i] == 0) ph[i] = 4;
            end
            default: ph[i] = 0;
          endcase
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic offer_job(input int t, input int s);
    @(negedge clk);
    job_valid = 1'b1;
    job_tiles = TW'(t);
    job_steps = SW'(s);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      #3;
      k++;
    end while (!(ph[0] == 0 && ph[1] == 0 && !busy_w[0] && !busy_w[1]) && k < bound);
    check("idle_timeout", 0, 32'(k < bound), 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset held with a job offered: nothing may be accepted.
    clear_stats();
    job_valid = 1'b1; job_tiles = 8'd1; job_steps = 8'd1;
    wt_valid = 1'b1; act_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    wait_idle(50);
    for (int i = 0; i < 2; i++) begin
      check("rst_job_done_cnt", i, 32'(n_done[i]), 32'd1);
      check("rst_job_exec_cnt", i, 32'(n_exec[i]), 32'd1);
    end

    // Basic job, 2 tiles x 3 steps, data always available.
    clear_stats();
    offer_job(2, 3);
    wait_idle(60);
    for (int i = 0; i < 2; i++) begin
      check("basic_exec_cnt", i, 32'(n_exec[i]), 32'd6);
      check("basic_load_cnt", i, 32'(n_load[i]), 32'd2);
      check("basic_fb_cnt",   i, 32'(n_fb[i]),   32'd5);
      check("basic_done_cnt", i, 32'(n_done[i]), 32'd1);
    end
    check("basic_done_gap", 0, 32'(done_gap[0]), 32'd9);
    check("basic_done_gap", 1, 32'(done_gap[1]), 32'd11);

    // Backpressure: weights arrive late, activations every other cycle.
    clear_stats();
    wt_valid = 1'b0; act_valid = 1'b0;
    offer_job(1, 4);
    for (int k = 2; k < 26; k++) begin
      @(negedge clk);
      wt_valid  = (k >= 4);
      act_valid = (k >= 5) && (k % 2 == 1);
    end
    act_valid = 1'b1;
    wait_idle(60);
    for (int i = 0; i < 2; i++) begin
      check("bp_wtreq_cycles", i, 32'(n_wtreq[i]), 32'd4);
      check("bp_exec_cnt",     i, 32'(n_exec[i]),  32'd4);
      check("bp_done_cnt",     i, 32'(n_done[i]),  32'd1);
    end

    // Zero-size jobs finish one cycle after acceptance with no strobes.
    clear_stats();
    offer_job(0, 5);
    wait_idle(20);
    check("zero_t_gap", 0, 32'(done_gap[0]), 32'd1);
    check("zero_t_gap", 1, 32'(done_gap[1]), 32'd1);
    offer_job(3, 0);
    wait_idle(20);
    for (int i = 0; i < 2; i++) begin
      check("zero_s_gap",     i, 32'(done_gap[i]), 32'd1);
      check("zero_done_cnt",  i, 32'(n_done[i]),   32'd2);
      check("zero_strobes",   i, 32'(n_exec[i] + n_load[i] + n_wtreq[i]), 32'd0);
    end

    // Abort in the second tile, then a clean single-step job.
    clear_stats();
    offer_job(4, 2);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("abort_done_cnt", 0, 32'(n_done[0]), 32'd0);
    check("abort_done_cnt", 1, 32'(n_done[1]), 32'd0);
    clear_stats();
    offer_job(1, 1);
    wait_idle(30);
    for (int i = 0; i < 2; i++) begin
      check("post_abort_done", i, 32'(n_done[i]), 32'd1);
      check("post_abort_fb",   i, 32'(n_fb[i]),   32'd0);
    end

    // Back-to-back single-step jobs with job_valid held.
    clear_stats();
    @(negedge clk);
    job_valid = 1'b1; job_tiles = 8'd1; job_steps = 8'd1;
    repeat (30) @(negedge clk);
    job_valid = 1'b0;
    wait_idle(30);
    check("b2b_interval", 0, 32'(done_int[0]), 32'd4);
    check("b2b_interval", 1, 32'(done_int[1]), 32'd6);
    check("b2b_fb_cnt",   0, 32'(n_fb[0]), 32'd0);
    check("b2b_fb_cnt",   1, 32'(n_fb[1]), 32'd0);
    check("b2b_exec_eq_done", 0, 32'(n_exec[0]), 32'(n_done[0]));
    check("b2b_exec_eq_done", 1, 32'(n_exec[1]), 32'(n_done[1]));

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
